cache_assoc: RTL and testbench
==============================

// Module: cache_assoc
// PURPOSE
//  Parametrised N-way set-associative, write-back, write-allocate data cache. Sits between
//  the CPU load/store port and the block-wide memory port. Owns tag/valid/dirty/LRU state.
//  Owns the miss FSM: victim write-back, then refill, then replay.
//  Successor to the single-way direct-mapped cache block.
// PARAMETERS
//  WAYS   2   associativity; 1, 2 or 4
//  SETS   32  sets per way; power of 2, >= 2
//  WORDS  4   32-bit words per line; power of 2, >= 2
//  Derived: OFF=log2(WORDS)+2, IDX=log2(SETS), TAG=32-IDX-OFF, BLK=WORDS*32
// PORTS
//  clk         in   1    single clock; all state on rising edge
//  rst         in   1    asynchronous, active-high reset
//  req_valid   in   1    CPU request present
//  req_we      in   1    1 = store, 0 = load
//  req_addr    in   32   byte address; [1:0] ignored
//  req_wdata   in   32   store data
//  req_ready   out  1    1 only in IDLE; request accepted when req_valid&&req_ready
//  resp_valid  out  1    one-cycle pulse; load data valid or store complete
//  resp_rdata  out  32   load data; 0 for stores
//  mem_req     out  1    memory transfer requested; held high until mem_done
//  mem_we      out  1    1 = write-back of mem_wblk, 0 = refill read
//  mem_addr    out  32   line-aligned address; low OFF bits are 0
//  mem_wblk    out  BLK  victim line data
//  mem_rblk    in   BLK  refill data; sampled in the mem_done cycle
//  mem_done    in   1    one-cycle completion pulse from memory
// BEHAVIOUR
//  Reset (async, rst=1):
//   - State goes to IDLE. All valid, dirty and LRU state clears.
//   - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wblk=0.
//   - Data/tag arrays are not cleared.
//   - A reset mid-transfer abandons it. No response is issued for the lost request.
//  Address split: tag=addr[31:IDX+OFF], index=addr[IDX+OFF-1:OFF], word=addr[OFF-1:2].
//  States:
//   IDLE: on accept, register addr/we/wdata and go to LOOKUP.
//   LOOKUP: compare the tag against all ways of the set (hit = valid && tag match).
//    - Hit: update the line, then resp_valid=1 in the next cycle; go to IDLE.
//    - Load hit: resp_rdata = selected word.
//    - Store hit: write the word and set dirty. Other words are unchanged.
//    - Miss: latch the victim way. Dirty victim -> WBACK, else -> REFILL.
//   WBACK: mem_req=1, mem_we=1, mem_addr={victim tag,index,0}, mem_wblk=victim line.
//    - All outputs are stable until mem_done; then go to REFILL.
//   REFILL: mem_req=1, mem_we=0, mem_addr={req tag,index,0}.
//    - On mem_done: write mem_rblk to the victim way (valid=1, dirty=0, new tag), then go to LOOKUP.
//    - The replay in LOOKUP hits, so store merge and LRU update happen there.
//  Latency (req accept to resp_valid):
//   - Hit: 2 cycles.
//   - Clean miss: 3 + refill wait.
//   - Dirty miss: adds the write-back wait.
//  mem_done outside WBACK/REFILL is ignored. req_valid outside IDLE is ignored; the CPU holds it.
//  Victim choice: lowest-numbered invalid way; if none, the way with the maximum LRU age.
//  LRU:
//   - Per set, per way, a log2(WAYS)-bit age. Ages always form a permutation of 0..WAYS-1.
//   - Reset sets age = way index.
//   - On a hit to way w: ages smaller than age[w] increment, then age[w]=0.
//   - A refill does not touch LRU; the replay hit updates it.
//   - WAYS=1: no LRU storage; the victim is always way 0.
//  Only one way matches at a time. Refill writes only on a miss, so duplicate tags cannot arise.
// STRUCTURE
//  Shared header cache_defs.vh:
//   - state encodings: IDLE, LOOKUP, WBACK, REFILL
//   - field-width macros: OFF/IDX/TAG formulas
//  Sub-module cache_lru (params WAYS, SETS):
//   - age arrays
//   - inputs: set index, valid mask, hit way, update strobe
//   - output: victim way
//  Tag/valid/dirty and data arrays are in this module as register arrays.
// TESTING
//  1. rst pulse mid-REFILL (mem_req=1) -> same cycle: mem_req=0, req_ready=1; reload of addr -> miss.
//  2. Cold load of 0x0000_0104 -> REFILL with mem_addr=0x0000_0100.
//     Return mem_rblk word1=0xDEAD_BEEF -> resp_rdata=0xDEAD_BEEF. Repeat load -> hit in 2 cycles, no mem_req.
//  3. Store 0x1234_5678 to 0x104, then load 0x104 -> 0x1234_5678; other words of the line unchanged.
//  4. Default params (WAYS=2, SETS=32, WORDS=4): load 0x0100, 0x2100, 0x4100, all set 16.
//     The third evicts the 0x0100 line (oldest). Reload 0x2100 -> hit.
//  5. Dirty eviction: store to 0x0100, then miss on 0x2100 and 0x4100.
//     -> WBACK with mem_addr=0x0100 and the stored word in mem_wblk, then REFILL 0x4100.
//  6. mem_done delayed 20 cycles -> mem_req/mem_addr/mem_wblk stable for the whole wait.
//     req_ready=0 throughout and a stray req_valid is ignored.

Source files
------------

// File: rtl/cache_assoc_pkg.sv
// Shared definitions for the set-associative data cache.
//   state_t  : miss-handling FSM states
//   WORD_W   : CPU word width
//   way_bits : width of a way-number field (at least 1 bit, even for WAYS=1)
package cache_assoc_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WBACK,
    ST_REFILL
  } state_t;

  function automatic int unsigned way_bits(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_assoc_lru.sv
// Per-set LRU age tracking and victim selection.
//   clk, rst     : clock, asynchronous active-high reset (ages return to way index)
//   i_set        : set index being looked up / updated
//   i_valid      : valid bit of every way in that set
//   i_hit_way    : way that was hit
//   i_update     : strobe; age the set around i_hit_way
//   o_victim     : lowest invalid way, else the way with the maximum age
module cache_lru
  import cache_assoc_pkg::*;
#(
  parameter int unsigned WAYS = 2,
  parameter int unsigned SETS = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(SETS)-1:0]    i_set,
  input  logic [WAYS-1:0]            i_valid,
  input  logic [way_bits(WAYS)-1:0]  i_hit_way,
  input  logic                       i_update,
  output logic [way_bits(WAYS)-1:0]  o_victim
);

  localparam int unsigned WAW = way_bits(WAYS);

  if (WAYS == 1) begin : g_single
    assign o_victim = '0;
  end else begin : g_multi
    localparam int unsigned AW = $clog2(WAYS);

    logic [AW-1:0] r_age [SETS][WAYS];
    logic          w_found;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned s = 0; s < SETS; s++) begin
          for (int unsigned w = 0; w < WAYS; w++) begin
            r_age[s][w] <= AW'(w);
          end
        end
      end else if (i_update) begin
        // Ages stay a permutation: only ways younger than the hit way move.
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (AW'(w) == i_hit_way) begin
            r_age[i_set][w] <= '0;
          end else if (r_age[i_set][w] < r_age[i_set][i_hit_way]) begin
            r_age[i_set][w] <= r_age[i_set][w] + 1'b1;
          end
        end
      end
    end

    always_comb begin
      o_victim = '0;
      w_found  = 1'b0;
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (!i_valid[w] && !w_found) begin
          o_victim = WAW'(w);
          w_found  = 1'b1;
        end
      end
      if (!w_found) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (r_age[i_set][w] == AW'(WAYS - 1)) begin
            o_victim = WAW'(w);
          end
        end
      end
    end
  end

endmodule

// File: rtl/cache_assoc.sv
// N-way set-associative, write-back, write-allocate data cache.
//   clk, rst                  : clock, asynchronous active-high reset
//   req_valid/we/addr/wdata   : CPU request (accepted when req_valid && req_ready)
//   req_ready                 : high only while idle
//   resp_valid/resp_rdata     : one-cycle response; rdata is 0 for stores
//   mem_req/we/addr/wblk      : block memory request, held until mem_done
//   mem_rblk, mem_done        : refill data and completion pulse
// Misses: dirty victim write-back, then refill, then replay through LOOKUP.
module cache_assoc
  import cache_assoc_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned SETS  = 32,
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [WORDS*32-1:0]   mem_wblk,
  input  logic [WORDS*32-1:0]   mem_rblk,
  input  logic                  mem_done
);

  localparam int unsigned OFF = $clog2(WORDS) + 2;
  localparam int unsigned IDX = $clog2(SETS);
  localparam int unsigned TAG = 32 - IDX - OFF;
  localparam int unsigned BLK = WORDS * WORD_W;
  localparam int unsigned WAW = way_bits(WAYS);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:2]           r_addr;
  logic                  r_we;
  logic [WORD_W-1:0]     r_wdata;
  logic [WAW-1:0]        r_victim;
  logic                  r_resp_valid;
  logic [WORD_W-1:0]     r_resp_rdata;

  logic [TAG-1:0]        r_tag   [WAYS][SETS];
  logic [BLK-1:0]        r_data  [WAYS][SETS];
  logic [SETS-1:0]       r_valid [WAYS];
  logic [SETS-1:0]       r_dirty [WAYS];

  logic [TAG-1:0]        w_tag;
  logic [IDX-1:0]        w_idx;
  logic [OFF-3:0]        w_word;
  logic                  w_hit;
  logic [WAW-1:0]        w_hit_way;
  logic [WAYS-1:0]       w_valid_mask;
  logic [WAW-1:0]        w_lru_victim;
  logic                  w_vic_dirty;
  logic [BLK-1:0]        w_hit_line;
  logic [WORD_W-1:0]     w_hit_word;
  logic                  w_lru_update;
  logic                  w_unused_addr_lsb;

  // Byte offset within a word has no meaning for a word-granular cache.
  assign w_unused_addr_lsb = ^req_addr[1:0];

  assign w_tag  = r_addr[31:IDX+OFF];
  assign w_idx  = r_addr[IDX+OFF-1:OFF];
  assign w_word = r_addr[OFF-1:2];

  always_comb begin
    w_hit        = 1'b0;
    w_hit_way    = '0;
    w_valid_mask = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      w_valid_mask[w] = r_valid[w][w_idx];
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAW'(w);
      end
    end
  end

  assign w_hit_line   = r_data[w_hit_way][w_idx];
  assign w_hit_word   = w_hit_line[32*w_word +: 32];
  assign w_vic_dirty  = r_valid[w_lru_victim][w_idx] & r_dirty[w_lru_victim][w_idx];
  assign w_lru_update = (r_state == ST_LOOKUP) && w_hit;

  cache_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk       (clk),
    .rst       (rst),
    .i_set     (w_idx),
    .i_valid   (w_valid_mask),
    .i_hit_way (w_hit_way),
    .i_update  (w_lru_update),
    .o_victim  (w_lru_victim)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wblk    = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (w_hit)            w_state_nxt = ST_IDLE;
        else if (w_vic_dirty) w_state_nxt = ST_WBACK;
        else                  w_state_nxt = ST_REFILL;
      end
      ST_WBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {r_tag[r_victim][w_idx], w_idx, {OFF{1'b0}}};
        mem_wblk = r_data[r_victim][w_idx];
        if (mem_done) w_state_nxt = ST_REFILL;
      end
      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {r_addr[31:OFF], {OFF{1'b0}}};
        if (mem_done) w_state_nxt = ST_LOOKUP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_victim     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr[31:2];
            r_we    <= req_we;
            r_wdata <= req_wdata;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_we ? '0 : w_hit_word;
            if (r_we) r_dirty[w_hit_way][w_idx] <= 1'b1;
          end else begin
            r_victim <= w_lru_victim;
          end
        end
        ST_REFILL: begin
          if (mem_done) begin
            r_valid[r_victim][w_idx] <= 1'b1;
            r_dirty[r_victim][w_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (r_state == ST_LOOKUP && w_hit && r_we) begin
      r_data[w_hit_way][w_idx][32*w_word +: 32] <= r_wdata;
    end
    if (r_state == ST_REFILL && mem_done) begin
      r_data[r_victim][w_idx] <= mem_rblk;
      r_tag[r_victim][w_idx]  <= w_tag;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_cache_assoc.sv
module tb_cache_assoc;

  localparam int WAYS  = 2;
  localparam int SETS  = 32;
  localparam int WORDS = 4;
  localparam int BLK   = WORDS * 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_we;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic            req_ready;
  logic            resp_valid;
  logic [31:0]     resp_rdata;
  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [BLK-1:0]  mem_wblk;
  logic [BLK-1:0]  mem_rblk;
  logic            mem_done;

  always #5 clk = ~clk;

  cache_assoc #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .WORDS (WORDS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wblk   (mem_wblk),
    .mem_rblk   (mem_rblk),
    .mem_done   (mem_done)
  );

  typedef struct {
    logic           we;
    logic [31:0]    addr;
    logic [BLK-1:0] blk;
  } xfer_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] sb [$];
  logic [31:0] bmem [int unsigned];
  logic [31:0] refm [int unsigned];
  xfer_t       xlog [$];
  int          mem_delay = 0;
  bit          mem_seen;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function logic [31:0] bmem_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return pat(a);
  endfunction

  function logic [31:0] ref_rd(input logic [31:0] a);
    if (refm.exists(a)) return refm[a];
    return pat(a);
  endfunction

  // Block memory responder: completes each transfer after mem_delay waiting cycles.
  initial begin : responder
    int    cnt;
    xfer_t x;
    cnt      = 0;
    mem_done = 1'b0;
    mem_rblk = '0;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      if (rst || !mem_req) begin
        cnt = 0;
      end else if (cnt >= mem_delay) begin
        x.we   = mem_we;
        x.addr = mem_addr;
        x.blk  = mem_wblk;
        if (mem_we) begin
          for (int k = 0; k < WORDS; k++) bmem[mem_addr + 32'(4*k)] = mem_wblk[32*k +: 32];
        end else begin
          for (int k = 0; k < WORDS; k++) mem_rblk[32*k +: 32] = bmem_rd(mem_addr + 32'(4*k));
        end
        xlog.push_back(x);
        mem_done = 1'b1;
        cnt      = 0;
      end else begin
        cnt++;
      end
    end
  end

  // Scoreboard: every response is matched against the oldest expected value.
  initial begin : monitor
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) mem_seen = 1'b1;
      if (resp_valid === 1'b1 && rst === 1'b0) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_resp got=%h want=none", resp_rdata);
        end else begin
          exp = sb.pop_front();
          if (resp_rdata !== exp) begin
            bad++;
            $display("FAIL resp_rdata got=%h want=%h", resp_rdata, exp);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output int nx);
    int start;
    int w;
    bit got;
    @(negedge clk);
    w = 0;
    while (req_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    sb.push_back(we ? 32'h0 : ref_rd(addr));
    if (we) refm[addr] = wd;
    start    = xlog.size();
    mem_seen = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (resp_valid === 1'b1) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL resp_timeout addr=%h got=none want=resp_valid", addr);
    end
    nx = xlog.size() - start;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    refm = bmem;
    sb.delete();
  endtask

  task automatic test_reset();
    int n;
    int lat;
    int nx;
    #2;
    total++;
    if ({req_ready, resp_valid, mem_req, mem_we} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=1000", {req_ready, resp_valid, mem_req, mem_we});
    end
    total++;
    if (resp_rdata !== 32'h0 || mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h want=0/0", resp_rdata, mem_addr);
    end
    total++;
    if (mem_wblk !== '0) begin
      bad++;
      $display("FAIL reset_wblk got=%h want=0", mem_wblk);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    refm = bmem;
    mem_delay = 1000;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_0200;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_0200) begin
      bad++;
      $display("FAIL refill_start got=%b/%b/%h want=1/0/00000200", mem_req, mem_we, mem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset got=%b/%b want=0/1", mem_req, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    refm = bmem;
    sb.delete();
    mem_delay = 0;
    do_req(1'b0, 32'h0000_0204, 32'h0, lat, nx);
    total++;
    if (nx != 1) begin
      bad++;
      $display("FAIL reload_after_reset xfers got=%0d want=1", nx);
    end
  endtask

  task automatic test_cold_load();
    int lat;
    int nx;
    bmem[32'h0000_0104] = 32'hDEAD_BEEF;
    refm[32'h0000_0104] = 32'hDEAD_BEEF;
    do_req(1'b0, 32'h0000_0104, 32'h0, lat, nx);
    total++;
    if (nx != 1 || xlog[$].we !== 1'b0 || xlog[$].addr !== 32'h0000_0100) begin
      bad++;
      $display("FAIL cold_refill got=%0d/%b/%h want=1/0/00000100", nx, xlog[$].we, xlog[$].addr);
    end
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL clean_miss_latency got=%0d want=4", lat);
    end
    do_req(1'b0, 32'h0000_0104, 32'h0, lat, nx);
    total++;
    if (lat != 2 || mem_seen) begin
      bad++;
      $display("FAIL hit_latency got=%0d/%b want=2/0", lat, mem_seen);
    end
  endtask

  task automatic test_store_merge();
    int lat;
    int nx;
    do_req(1'b1, 32'h0000_0104, 32'h1234_5678, lat, nx);
    total++;
    if (lat != 2 || nx != 0) begin
      bad++;
      $display("FAIL store_hit got=%0d/%0d want=2/0", lat, nx);
    end
    do_req(1'b0, 32'h0000_0104, 32'h0, lat, nx);
    do_req(1'b0, 32'h0000_0100, 32'h0, lat, nx);
    do_req(1'b0, 32'h0000_0108, 32'h0, lat, nx);
    do_req(1'b0, 32'h0000_010C, 32'h0, lat, nx);
    total++;
    if (nx != 0) begin
      bad++;
      $display("FAIL store_line_resident xfers got=%0d want=0", nx);
    end
  endtask

  task automatic test_lru_evict();
    int lat;
    int nx;
    do_reset();
    do_req(1'b0, 32'h0000_0100, 32'h0, lat, nx);
    do_req(1'b0, 32'h0000_2100, 32'h0, lat, nx);
    do_req(1'b0, 32'h0000_4100, 32'h0, lat, nx);
    total++;
    if (nx != 1 || xlog[$].we !== 1'b0 || xlog[$].addr !== 32'h0000_4100) begin
      bad++;
      $display("FAIL third_refill got=%0d/%b/%h want=1/0/00004100", nx, xlog[$].we, xlog[$].addr);
    end
    do_req(1'b0, 32'h0000_2100, 32'h0, lat, nx);
    total++;
    if (lat != 2 || nx != 0) begin
      bad++;
      $display("FAIL lru_keeps_2100 got=%0d/%0d want=2/0", lat, nx);
    end
    do_req(1'b0, 32'h0000_0100, 32'h0, lat, nx);
    total++;
    if (nx != 1) begin
      bad++;
      $display("FAIL lru_evicted_0100 xfers got=%0d want=1", nx);
    end
  endtask

  task automatic test_dirty_evict();
    int          lat;
    int          nx;
    logic [31:0] w0;
    xfer_t       wb;
    xfer_t       rf;
    do_reset();
    w0 = ref_rd(32'h0000_0100);
    do_req(1'b1, 32'h0000_0108, 32'hCAFE_F00D, lat, nx);
    do_req(1'b0, 32'h0000_2100, 32'h0, lat, nx);
    do_req(1'b0, 32'h0000_4100, 32'h0, lat, nx);
    total++;
    if (nx != 2 || lat != 5) begin
      bad++;
      $display("FAIL dirty_miss got=%0d xfers %0d cycles want=2 xfers 5 cycles", nx, lat);
    end
    if (xlog.size() >= 2) begin
      wb = xlog[xlog.size()-2];
      rf = xlog[xlog.size()-1];
      total++;
      if (wb.we !== 1'b1 || wb.addr !== 32'h0000_0100) begin
        bad++;
        $display("FAIL wback_addr got=%b/%h want=1/00000100", wb.we, wb.addr);
      end
      total++;
      if (wb.blk[95:64] !== 32'hCAFE_F00D || wb.blk[31:0] !== w0) begin
        bad++;
        $display("FAIL wback_data got=%h/%h want=cafef00d/%h", wb.blk[95:64], wb.blk[31:0], w0);
      end
      total++;
      if (rf.we !== 1'b0 || rf.addr !== 32'h0000_4100) begin
        bad++;
        $display("FAIL refill_after_wback got=%b/%h want=0/00004100", rf.we, rf.addr);
      end
    end
    do_req(1'b0, 32'h0000_0108, 32'h0, lat, nx);
    total++;
    if (nx != 1) begin
      bad++;
      $display("FAIL reload_written_back xfers got=%0d want=1", nx);
    end
  endtask

  task automatic test_stall();
    int             lat;
    int             nx;
    int             n;
    int             held;
    int             held2;
    int             unstable;
    logic [31:0]    cap_addr;
    logic [BLK-1:0] cap_blk;
    do_reset();
    mem_delay = 0;
    do_req(1'b1, 32'h0000_0100, 32'h0BAD_CAFE, lat, nx);
    do_req(1'b0, 32'h0000_2100, 32'h0, lat, nx);
    mem_delay = 20;
    fork
      do_req(1'b0, 32'h0000_4100, 32'h0, lat, nx);
      begin
        n = 0;
        while (!(mem_req === 1'b1 && mem_we === 1'b1) && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        cap_addr = mem_addr;
        cap_blk  = mem_wblk;
        total++;
        if (cap_addr !== 32'h0000_0100 || cap_blk[31:0] !== 32'h0BAD_CAFE) begin
          bad++;
          $display("FAIL stall_wback got=%h/%h want=00000100/0badcafe", cap_addr, cap_blk[31:0]);
        end
        held     = 0;
        unstable = 0;
        while (mem_req === 1'b1 && mem_we === 1'b1 && held < 100) begin
          if (mem_addr !== cap_addr || mem_wblk !== cap_blk || req_ready !== 1'b0) unstable++;
          if (held == 3) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h0000_8000;
            req_wdata = 32'hFFFF_FFFF;
          end
          if (held == 15) req_valid = 1'b0;
          @(posedge clk);
          #1;
          held++;
        end
        held2 = 0;
        while (mem_req === 1'b1 && mem_we === 1'b0 && held2 < 100) begin
          if (mem_addr !== 32'h0000_4100 || req_ready !== 1'b0) unstable++;
          @(posedge clk);
          #1;
          held2++;
        end
        total++;
        if (unstable != 0) begin
          bad++;
          $display("FAIL stall_stable got=%0d unstable cycles want=0", unstable);
        end
        total++;
        if (held < 20 || held2 < 20) begin
          bad++;
          $display("FAIL stall_length got=%0d/%0d want>=20/20", held, held2);
        end
      end
    join
    total++;
    if (nx != 2 || lat != 45) begin
      bad++;
      $display("FAIL stall_latency got=%0d xfers %0d cycles want=2 xfers 45 cycles", nx, lat);
    end
    mem_delay = 0;
    repeat (5) @(negedge clk);
    do_req(1'b0, 32'h0000_8000, 32'h0, lat, nx);
    total++;
    if (nx != 1) begin
      bad++;
      $display("FAIL stray_ignored xfers got=%0d want=1", nx);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    mem_seen  = 1'b0;
    test_reset();
    test_cold_load();
    test_store_merge();
    test_lru_evict();
    test_dirty_evict();
    test_stall();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
